// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 scancode set 2 parser with modifier, caps-lock and response tracking
module ps2_scancode_decoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 main_clk,
  input  logic                 reset,
  input  logic [7:0]           byte_in,
  input  logic                 byte_parity_err,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic [7:0]           event_code,
  output logic                 event_extended,
  output logic                 event_released,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [5:0]           modifiers,
  output logic                 caps_lock,
  output logic                 ack_pulse,
  output logic                 bat_ok_pulse,
  output logic                 bat_fail_pulse,
  output logic                 echo_pulse,
  output logic                 resend_pulse,
  output logic                 overrun_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clear
);

  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_BRK   = 8'hF0;
  localparam logic [7:0] B_PAUSE = 8'hE1;
  localparam logic [7:0] K_LSHIFT = 8'h12;
  localparam logic [7:0] K_RSHIFT = 8'h59;
  localparam logic [7:0] K_CTRL   = 8'h14;
  localparam logic [7:0] K_ALT    = 8'h11;
  localparam logic [7:0] K_CAPS   = 8'h58;
  localparam logic [7:0] K_PAUSE  = 8'h77;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_PAUSE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] pause_idx;
  logic [2:0] pause_idx_nxt;
  logic       accept;

  // decode results for the byte accepted this cycle
  logic       dec_load;
  logic [7:0] dec_code;
  logic       dec_ext;
  logic       dec_rel;
  logic       dec_seq_err;
  logic       dec_par_err;
  logic [5:0] dec_strobe;
  logic       mod_hit;
  logic [2:0] mod_bit;
  logic       caps_held;

  // tail bytes of the Pause sequence after the leading E1
  function automatic logic [7:0] pause_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    pause_byte = 8'h14;
      3'd1:    pause_byte = 8'h77;
      3'd2:    pause_byte = 8'hE1;
      3'd3:    pause_byte = 8'hF0;
      3'd4:    pause_byte = 8'h14;
      3'd5:    pause_byte = 8'hF0;
      default: pause_byte = 8'h77;
    endcase
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    is_prefix = (b == B_EXT) || (b == B_BRK) || (b == B_PAUSE);
  endfunction

  // extended 12/59 are the fake shifts some keyboards wrap around nav keys
  function automatic logic is_fake_shift(input logic [7:0] b);
    is_fake_shift = (b == K_LSHIFT) || (b == K_RSHIFT);
  endfunction

  assign byte_ready = !reset && (!event_valid || event_ready);
  assign accept     = byte_valid && byte_ready;

  // parser state register
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pause_idx <= 3'd0;
    end else begin
      state     <= state_nxt;
      pause_idx <= pause_idx_nxt;
    end
  end

  // parser next-state: walk prefixes, bail to IDLE on any bad byte
  always_comb begin
    state_nxt     = state;
    pause_idx_nxt = pause_idx;
    if (accept) begin
      if (byte_parity_err) begin
        state_nxt     = ST_IDLE;
        pause_idx_nxt = 3'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            pause_idx_nxt = 3'd0;
            if (byte_in == B_EXT)        state_nxt = ST_EXT;
            else if (byte_in == B_BRK)   state_nxt = ST_BRK;
            else if (byte_in == B_PAUSE) state_nxt = ST_PAUSE;
            else                         state_nxt = ST_IDLE;
          end
          ST_EXT: begin
            if (byte_in == B_BRK)      state_nxt = ST_EXTBRK;
            else if (byte_in == B_EXT) state_nxt = ST_EXT;
            else                       state_nxt = ST_IDLE;
          end
          ST_BRK, ST_EXTBRK: begin
            state_nxt = ST_IDLE;
          end
          ST_PAUSE: begin
            if (byte_in == pause_byte(pause_idx) && pause_idx != 3'd6) begin
              pause_idx_nxt = pause_idx + 3'd1;
            end else begin
              state_nxt     = ST_IDLE;
              pause_idx_nxt = 3'd0;
            end
          end
          default: begin
            state_nxt     = ST_IDLE;
            pause_idx_nxt = 3'd0;
          end
        endcase
      end
    end
  end

  // parser outputs: event to load, response strobe, or error for this byte
  always_comb begin
    dec_load    = 1'b0;
    dec_code    = byte_in;
    dec_ext     = 1'b0;
    dec_rel     = 1'b0;
    dec_seq_err = 1'b0;
    dec_par_err = 1'b0;
    dec_strobe  = 6'd0;
    if (accept) begin
      if (byte_parity_err) begin
        dec_par_err = 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            case (byte_in)
              B_EXT, B_BRK, B_PAUSE: dec_load = 1'b0;
              8'hFA:                 dec_strobe = 6'b100000;
              8'hAA:                 dec_strobe = 6'b010000;
              8'hFC, 8'hFD:          dec_strobe = 6'b001000;
              8'hEE:                 dec_strobe = 6'b000100;
              8'hFE:                 dec_strobe = 6'b000010;
              8'h00, 8'hFF:          dec_strobe = 6'b000001;
              default:               dec_load = 1'b1;
            endcase
          end
          ST_EXT: begin
            dec_ext = 1'b1;
            if (byte_in != B_BRK && byte_in != B_EXT && !is_fake_shift(byte_in)) begin
              dec_load = 1'b1;
            end
          end
          ST_BRK: begin
            dec_rel = 1'b1;
            if (is_prefix(byte_in)) dec_seq_err = 1'b1;
            else                    dec_load    = 1'b1;
          end
          ST_EXTBRK: begin
            dec_ext = 1'b1;
            dec_rel = 1'b1;
            if (is_prefix(byte_in))          dec_seq_err = 1'b1;
            else if (!is_fake_shift(byte_in)) dec_load    = 1'b1;
          end
          ST_PAUSE: begin
            if (byte_in != pause_byte(pause_idx)) begin
              dec_seq_err = 1'b1;
            end else if (pause_idx == 3'd6) begin
              dec_load = 1'b1;
              dec_code = K_PAUSE;
              dec_ext  = 1'b1;
            end
          end
          default: dec_seq_err = 1'b0;
        endcase
      end
    end
  end

  // map a decoded code onto its modifier bit {ralt, lalt, rctrl, lctrl, rshift, lshift}
  always_comb begin
    mod_hit = 1'b0;
    mod_bit = 3'd0;
    case (dec_code)
      K_LSHIFT: begin mod_hit = 1'b1; mod_bit = 3'd0; end
      K_RSHIFT: begin mod_hit = 1'b1; mod_bit = 3'd1; end
      K_CTRL:   begin mod_hit = 1'b1; mod_bit = dec_ext ? 3'd3 : 3'd2; end
      K_ALT:    begin mod_hit = 1'b1; mod_bit = dec_ext ? 3'd5 : 3'd4; end
      default:  begin mod_hit = 1'b0; mod_bit = 3'd0; end
    endcase
  end

  // event register: a new event overrides the pop in the same cycle
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      event_valid    <= 1'b0;
      event_code     <= 8'd0;
      event_extended <= 1'b0;
      event_released <= 1'b0;
    end else if (dec_load) begin
      event_valid    <= 1'b1;
      event_code     <= dec_code;
      event_extended <= dec_ext;
      event_released <= dec_rel;
    end else if (event_valid && event_ready) begin
      event_valid <= 1'b0;
    end
  end

  // modifier and caps-lock tracking, updated alongside the event load
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      modifiers <= 6'd0;
      caps_lock <= 1'b0;
      caps_held <= 1'b0;
    end else if (dec_load) begin
      if (mod_hit) modifiers[mod_bit] <= !dec_rel;
      if (dec_code == K_CAPS && !dec_ext) begin
        if (dec_rel) begin
          caps_held <= 1'b0;
        end else if (!caps_held) begin
          caps_lock <= !caps_lock;
          caps_held <= 1'b1;
        end
      end
    end
  end

  // single-cycle response strobes
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      {ack_pulse, bat_ok_pulse, bat_fail_pulse, echo_pulse, resend_pulse, overrun_pulse} <= 6'd0;
    end else begin
      {ack_pulse, bat_ok_pulse, bat_fail_pulse, echo_pulse, resend_pulse, overrun_pulse} <= dec_strobe;
    end
  end

  // saturating error counter; clear beats a coincident error
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_clear) begin
      err_count <= '0;
    end else if ((dec_par_err || dec_seq_err) && err_count != '1) begin
      err_count <= err_count + ERR_ONE;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - randomized bench for ps2_scancode_decoder against a sequence-matching model
module tb_ps2_scancode_decoder;

  logic       main_clk;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_parity_err;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] event_code;
  logic       event_extended;
  logic       event_released;
  logic       event_valid;
  logic       event_ready;
  logic [5:0] modifiers;
  logic       caps_lock;
  logic       ack_pulse, bat_ok_pulse, bat_fail_pulse, echo_pulse, resend_pulse, overrun_pulse;
  logic [7:0] err_count;
  logic       err_clear;

  ps2_scancode_decoder #(.ERR_CNT_W(8)) dut (
    .main_clk(main_clk), .reset(reset),
    .byte_in(byte_in), .byte_parity_err(byte_parity_err), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .event_code(event_code), .event_extended(event_extended), .event_released(event_released),
    .event_valid(event_valid), .event_ready(event_ready),
    .modifiers(modifiers), .caps_lock(caps_lock),
    .ack_pulse(ack_pulse), .bat_ok_pulse(bat_ok_pulse), .bat_fail_pulse(bat_fail_pulse),
    .echo_pulse(echo_pulse), .resend_pulse(resend_pulse), .overrun_pulse(overrun_pulse),
    .err_count(err_count), .err_clear(err_clear)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  int n_vec = 0;
  int n_err = 0;
  int cycles = 0;
  bit timed_out = 0;

  // stimulus queue: byte plus parity-error flag
  logic [7:0] qb[$];
  logic       qp[$];
  logic [7:0] cur_b;
  logic       cur_p;
  bit         have_byte = 0;
  int         rdy_pct = 7;
  int         clr_mode = 1;
  int         perr_pct = 0;

  // reference model state
  logic [7:0] seq[$];
  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  logic [7:0] key_tab [12] = '{8'h1C, 8'h1B, 8'h23, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h75, 8'h77, 8'h33, 8'h5A};
  logic [7:0] resp_tab [8] = '{8'hFA, 8'hAA, 8'hFC, 8'hFD, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  logic       m_ev_valid;
  logic [7:0] m_code;
  logic       m_ext, m_rel;
  logic [5:0] m_mods;
  logic       m_caps, m_held;
  logic [5:0] m_strobe;
  int         m_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_pfx(input logic [7:0] b);
    return b == 8'hE0 || b == 8'hF0 || b == 8'hE1;
  endfunction

  // one-hot {ack, bat_ok, bat_fail, echo, resend, overrun}, zero for ordinary bytes
  function automatic logic [5:0] resp_bits(input logic [7:0] b);
    case (b)
      8'hFA:        return 6'b100000;
      8'hAA:        return 6'b010000;
      8'hFC, 8'hFD: return 6'b001000;
      8'hEE:        return 6'b000100;
      8'hFE:        return 6'b000010;
      8'h00, 8'hFF: return 6'b000001;
      default:      return 6'b000000;
    endcase
  endfunction

  task automatic model_reset();
    seq.delete();
    m_ev_valid = 0; m_code = 0; m_ext = 0; m_rel = 0;
    m_mods = 0; m_caps = 0; m_held = 0; m_strobe = 0; m_err = 0;
  endtask

  // classify the whole byte sequence seen since the last complete item
  task automatic model_step(input logic acc);
    logic got_ev, err, done, ok, x, r;
    logic [7:0] c;
    int n;
    m_strobe = 0; got_ev = 0; err = 0; c = 0; x = 0; r = 0;
    if (acc) begin
      if (cur_p) begin
        err = 1;
        seq.delete();
      end else begin
        seq.push_back(cur_b);
        done = 1;
        if (seq[0] == 8'hE1) begin
          ok = 1;
          for (int i = 0; i < seq.size(); i++) if (seq[i] != pause_seq[i]) ok = 0;
          if (!ok) err = 1;
          else if (seq.size() == 8) begin got_ev = 1; c = 8'h77; x = 1; end
          else done = 0;
        end else begin
          n = 0;
          while (n < seq.size() && seq[n] == 8'hE0) n++;
          x = (n > 0);
          if (n == seq.size()) done = 0;
          else if (seq[n] == 8'hF0) begin
            if (seq.size() == n + 1) done = 0;
            else if (is_pfx(seq[n+1])) err = 1;
            else begin got_ev = 1; c = seq[n+1]; r = 1; end
          end else if (!x && resp_bits(seq[n]) != 0) m_strobe = resp_bits(seq[n]);
          else begin got_ev = 1; c = seq[n]; end
          if (got_ev && x && (c == 8'h12 || c == 8'h59)) got_ev = 0;
        end
        if (done) seq.delete();
      end
    end
    if (got_ev) begin
      m_ev_valid = 1; m_code = c; m_ext = x; m_rel = r;
      if (c == 8'h12) m_mods[0] = !r;
      if (c == 8'h59) m_mods[1] = !r;
      if (c == 8'h14) m_mods[x ? 3 : 2] = !r;
      if (c == 8'h11) m_mods[x ? 5 : 4] = !r;
      if (c == 8'h58 && !x) begin
        if (r) m_held = 0;
        else if (!m_held) begin m_caps = !m_caps; m_held = 1; end
      end
    end else if (m_ev_valid && event_ready) begin
      m_ev_valid = 0;
    end
    if (err_clear) m_err = 0;
    else if (err && m_err < 255) m_err++;
  endtask

  task automatic compare();
    logic exp_ready;
    exp_ready = !reset && (!m_ev_valid || event_ready);
    check_val("byte_ready", byte_ready, exp_ready);
    check_val("event_valid", event_valid, m_ev_valid);
    if (m_ev_valid) check_val("event", {event_code, event_extended, event_released}, {m_code, m_ext, m_rel});
    check_val("strobes", {ack_pulse, bat_ok_pulse, bat_fail_pulse, echo_pulse, resend_pulse, overrun_pulse}, m_strobe);
    check_val("modifiers", modifiers, m_mods);
    check_val("caps_lock", caps_lock, m_caps);
    check_val("err_count", err_count, m_err);
  endtask

  task automatic run_cycle();
    logic acc;
    @(negedge main_clk);
    if (!have_byte && qb.size() > 0) begin
      cur_b = qb.pop_front();
      cur_p = qp.pop_front();
      have_byte = 1;
    end
    byte_valid      = have_byte && ($urandom_range(0, 9) < 7);
    byte_in         = have_byte ? cur_b : 8'h00;
    byte_parity_err = have_byte ? cur_p : 1'b0;
    event_ready     = ($urandom_range(0, 9) < rdy_pct);
    err_clear       = (clr_mode == 2) || (clr_mode == 1 && $urandom_range(0, 63) == 0);
    #1;
    compare();
    acc = byte_valid && (!m_ev_valid || event_ready);
    @(posedge main_clk);
    model_step(acc);
    if (acc) have_byte = 0;
    cycles++;
  endtask

  task automatic drain();
    while (!timed_out && (qb.size() > 0 || have_byte)) begin
      run_cycle();
      if (cycles > 60000) begin
        timed_out = 1;
        check_val("cycle_budget", 32'd1, 32'd0);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge main_clk);
    reset = 1; byte_valid = 0; err_clear = 0;
    model_reset();
    repeat (2) begin
      #1 compare();
      @(negedge main_clk);
    end
    reset = 0;
  endtask

  task automatic push(input logic [7:0] b);
    qb.push_back(b);
    qp.push_back($urandom_range(0, 99) < perr_pct);
  endtask

  task automatic push_perr(input logic [7:0] b);
    qb.push_back(b);
    qp.push_back(1'b1);
  endtask

  task automatic push_list(input logic [7:0] l [], input int len);
    for (int i = 0; i < len; i++) push(l[i]);
  endtask

  task automatic push_scenario();
    logic [7:0] k;
    int kind, len;
    k = key_tab[$urandom_range(0, 11)];
    kind = $urandom_range(0, 11);
    case (kind)
      0: push(k);
      1: begin push(8'hF0); push(k); end
      2: begin push(8'hE0); push(k); end
      3: begin push(8'hE0); push(8'hF0); push(k); end
      4: begin push(8'hE0); push($urandom_range(0, 1) ? 8'h12 : 8'h59); end
      5: for (int i = 0; i < 8; i++) push(pause_seq[i]);
      6: begin
        len = $urandom_range(1, 7);
        for (int i = 0; i < len; i++) push(pause_seq[i]);
        push(8'($urandom));
      end
      7: push(resp_tab[$urandom_range(0, 7)]);
      8: push(8'($urandom));
      9: begin push(8'hF0); push($urandom_range(0, 1) ? 8'hE0 : 8'hE1); end
      10: begin
        len = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) push(8'h58);
        push(8'hF0); push(8'h58);
      end
      default: begin push(8'hE0); push(8'hE0); push(k); end
    endcase
  endtask

  initial begin
    reset = 1; byte_in = 0; byte_parity_err = 0; byte_valid = 0; event_ready = 0; err_clear = 0;
    model_reset();
    @(negedge main_clk);
    #1 compare();
    @(negedge main_clk);
    reset = 0;

    // directed sequences from the test plan, checked cycle by cycle via the model
    clr_mode = 0;
    perr_pct = 0;
    push(8'h1C); push(8'hF0); push(8'h1C);
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75); push(8'hE0); push(8'h12);
    push(8'h1C); push(8'h12); push(8'h58); push(8'h58); push(8'hF0); push(8'h58); push(8'h58);
    for (int i = 0; i < 8; i++) push(pause_seq[i]);
    push(8'hE1); push(8'h14); push(8'h33); push(8'h1C);
    push(8'hFA); push(8'hAA); push(8'hFE);
    push(8'hE0); push_perr(8'h5A); push(8'h1C);
    drain();

    // clear beats a coincident error
    clr_mode = 2;
    push_perr(8'h1C); push(8'hF0); push(8'hE0);
    drain();

    // saturation of the error counter
    clr_mode = 0;
    for (int i = 0; i < 270; i++) push_perr(8'($urandom));
    drain();
    clr_mode = 1;

    // randomized scenarios with occasional mid-sequence resets
    perr_pct = 4;
    for (int s = 0; s < 500 && !timed_out; s++) begin
      rdy_pct = $urandom_range(3, 10);
      push_scenario();
      if (s % 100 == 50) begin
        repeat (2) run_cycle();
        do_reset();
      end
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
